// File: rtl/jacobi_vmat_bank_if.sv
// Update handshake bundle for jacobi_vmat_bank.
// The producer (rotation unit) is the master and the register bank is the slave.
// upd_mat is row-major: element (r,c) sits at bits [(r*N+c)*W +: W].
interface jacobi_vmat_bank_if #(
  parameter int W = 21,
  parameter int N = 3
);
  logic             upd_valid;
  logic             upd_ready;
  logic [N*N*W-1:0] upd_mat;

  modport master (output upd_valid, output upd_mat, input upd_ready);
  modport slave  (input upd_valid, input upd_mat, output upd_ready);
endinterface

// File: rtl/jacobi_vmat_bank.sv
// jacobi_vmat_bank: NxN eigenvector-matrix register bank for the Jacobi
// rotation loop of the OBB covariance eigen-solver.
// - start loads a scaled identity and arms the bank (RUN).
// - Each accepted rotation result overwrites the whole matrix and bumps iter_cnt.
// - After MAX_ITER accepted updates the bank raises done and freezes the matrix.
// Optional feature macro: VMAT_CONV_EN. When defined, an update whose elements
// all differ from the held matrix by less than CONV_TH also ends the loop and
// raises converged. When undefined, converged is tied low.
module jacobi_vmat_bank #(
  parameter int                 W          = 21,
  parameter int                 N          = 3,
  parameter int                 SCALE      = 100,
  parameter int                 MAX_ITER   = 7,
  parameter int                 STATE_W    = 4,
  parameter logic [STATE_W-1:0] LOAD_STATE = 4'b1001,
  parameter int                 CONV_TH    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [STATE_W-1:0]              state_i,
  jacobi_vmat_bank_if.slave               upd,
  output logic [N*N*W-1:0]                mat_o,
  output logic                            mat_valid,
  output logic [$clog2(MAX_ITER+1)-1:0]   iter_cnt,
  output logic                            done,
  output logic                            converged
);

  localparam int ITER_W = $clog2(MAX_ITER + 1);
  localparam int NE     = N * N;
  localparam int MAT_W  = NE * W;

  localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Scaled identity: SCALE on the diagonal (sign-extended to W), zero elsewhere.
  function automatic logic [MAT_W-1:0] identity_mat();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) begin
      m[(r*N+r)*W +: W] = W'(SCALE);
    end
    return m;
  endfunction

  localparam logic [MAT_W-1:0] IDENT = identity_mat();

  state_t              state_q, state_d;
  logic [MAT_W-1:0]    mat_q, mat_d;
  logic                mat_valid_q, mat_valid_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic                done_q, done_d;
  logic                conv_q, conv_d;

  logic                ready;
  logic                accept;
  logic [ITER_W-1:0]   iter_inc;
  logic                conv_hit;

`ifdef VMAT_CONV_EN
  // Magnitude of a - b, computed one bit wider so no difference can overflow.
  function automatic logic [W:0] abs_diff(logic signed [W-1:0] a,
                                          logic signed [W-1:0] b);
    logic signed [W:0] d;
    d = {a[W-1], a} - {b[W-1], b};
    return d[W] ? (W+1)'(-d) : (W+1)'(d);
  endfunction

  // Early-termination test: every element of the incoming matrix is within
  // CONV_TH of the held matrix (equivalent to max |diff| < CONV_TH).
  always_comb begin
    conv_hit = 1'b1;
    for (int e = 0; e < NE; e++) begin
      if (abs_diff(upd.upd_mat[e*W +: W], mat_q[e*W +: W]) >= (W+1)'(CONV_TH)) begin
        conv_hit = 1'b0;
      end
    end
  end
`else
  // Without the convergence feature only the iteration limit ends the loop;
  // CONV_TH is referenced only so the parameter list stays identical.
  assign conv_hit = 1'b0 && (CONV_TH < 0);
`endif

  // Next-state and handshake: start outranks an update in the same cycle.
  always_comb begin
    state_d     = state_q;
    mat_d       = mat_q;
    mat_valid_d = mat_valid_q;
    iter_d      = iter_q;
    done_d      = done_q;
    conv_d      = conv_q;

    ready    = (state_q == ST_RUN) && (state_i == LOAD_STATE);
    accept   = upd.upd_valid && ready;
    iter_inc = iter_q + 1'b1;

    if (start) begin
      state_d     = ST_RUN;
      mat_d       = IDENT;
      mat_valid_d = 1'b1;
      iter_d      = '0;
      done_d      = 1'b0;
      conv_d      = 1'b0;
    end else if (accept) begin
      mat_d       = upd.upd_mat;
      mat_valid_d = 1'b1;
      iter_d      = iter_inc;
      if ((iter_inc == MAX_ITER_C) || conv_hit) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        conv_d  = conv_hit;
      end
    end
  end

  // State, matrix and status registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mat_q       <= '0;
      mat_valid_q <= 1'b0;
      iter_q      <= '0;
      done_q      <= 1'b0;
      conv_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mat_q       <= mat_d;
      mat_valid_q <= mat_valid_d;
      iter_q      <= iter_d;
      done_q      <= done_d;
      conv_q      <= conv_d;
    end
  end

  assign upd.upd_ready = ready;
  assign mat_o         = mat_q;
  assign mat_valid     = mat_valid_q;
  assign iter_cnt      = iter_q;
  assign done          = done_q;
  assign converged     = conv_q;

endmodule

// File: doc/jacobi_vmat_bank.md
Name: jacobi_vmat_bank

Overview:
- Parametrised NxN eigenvector-matrix register bank for the Jacobi rotation loop in the OBB covariance eigen-solver.
- On start, loads a scaled identity. Each accepted rotation result then overwrites the matrix, and the bank counts iterations.
- Flags completion after MAX_ITER updates and holds the final V matrix for the OBB axis-projection stage.
- Generalises the fixed 3x3/21-bit iteration-0 identity mux with:
  - width, size and scale parameters;
  - a valid/ready handshake;
  - an internal iteration counter and done flag.

Parameters:
- W, 21, signed element width (two's complement).
- N, 3, matrix dimension (N x N elements).
- SCALE, 100, fixed-point value of 1.0 written on the diagonal at init.
- MAX_ITER, 7, number of accepted updates before DONE (must be >= 1).
- STATE_W, 4, width of the top-level controller state bus.
- LOAD_STATE, 4'b1001, controller state code in which updates are accepted.
- CONV_TH, 2, convergence threshold (used only with VMAT_CONV_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse: (re)initialise to scaled identity.
- state_i  input  STATE_W  top-level controller state.
- upd_valid  input  1  upd_mat carries a new rotated V matrix.
- upd_ready  output  1  bank will accept an update this cycle.
- upd_mat  input  N*N*W  new matrix, row-major; element (r,c) at bits [(r*N+c)*W +: W].
- mat_o  output  N*N*W  current matrix, same packing; registered.
- mat_valid  output  1  mat_o holds a defined matrix (init or update).
- iter_cnt  output  $clog2(MAX_ITER+1)  number of accepted updates since last start.
- done  output  1  MAX_ITER updates reached (or converged); matrix frozen.
- converged  output  1  early termination by threshold (VMAT_CONV_EN only).

Behaviour:
- Reset (rst=1 at an edge):
  - state IDLE;
  - mat_o=0, mat_valid=0, iter_cnt=0, done=0, converged=0;
  - rst has priority over every other input.
- FSM states: IDLE, RUN, DONE. The state register is internal.
- upd_ready = (fsm==RUN) && (state_i==LOAD_STATE). It is combinational from registered state and the state_i input.
- start=1 in any state:
  - next edge: mat_o <= identity (diagonal SCALE, off-diagonal 0, sign-extended to W);
  - iter_cnt <= 0, done <= 0, converged <= 0, mat_valid <= 1, fsm <= RUN.
  - Latency: identity visible on mat_o one cycle after start.
- start has priority over a simultaneous handshake: the update in that cycle is dropped and not counted.
- Handshake in RUN: accept when upd_valid && upd_ready.
  - next edge: mat_o <= upd_mat (all N*N elements at once), iter_cnt <= iter_cnt+1.
  - If iter_cnt+1 == MAX_ITER: fsm <= DONE and done <= 1 on the same edge.
- upd_valid while state_i != LOAD_STATE: no effect; the producer must hold data until upd_ready.
- IDLE and DONE: upd_ready=0; upd_valid ignored; mat_o, iter_cnt and done held.
  - DONE is left only by start (back to RUN) or rst (to IDLE).
- Arithmetic:
  - no arithmetic on the data path; values are stored verbatim;
  - SCALE must be representable in W signed bits (elaboration-time check is recommended).
- iter_cnt never exceeds MAX_ITER; no wrap-around.
- Reset mid-RUN abandons the iteration; mat_valid drops on the following cycle.

Optional Feature:
- Macro VMAT_CONV_EN.
- Defined:
  - on each accepted update, compute |upd_mat[e] - mat_o[e]| in W+1 bits for every element;
  - if the maximum is < CONV_TH, then on the same edge fsm <= DONE, done <= 1, converged <= 1, and the matrix is still latched;
  - the MAX_ITER limit still applies, and converged stays 0 if only the limit triggers;
  - purely combinational compare; no added latency.
- Not defined: converged is tied to 0; only the MAX_ITER terminates.

Test Plan:
- Reset, then start with N=3, W=21, SCALE=100 -> the cycle after start, mat_o elements = {100,0,0,0,100,0,0,0,100}, mat_valid=1, iter_cnt=0, done=0.
- state_i=4'b1001, 7 back-to-back upd_valid with distinct matrices (element0 = 1..7) -> iter_cnt steps 1..7; done=1 on the edge of the 7th accept; upd_ready=0 afterwards; mat_o element0=7 held.
- upd_valid=1 with state_i=4'b0011 for 5 cycles -> upd_ready=0, mat_o and iter_cnt unchanged.
- After 3 updates, assert start and upd_valid in the same cycle -> mat_o=identity, iter_cnt=0; the update is not counted.
- In DONE, drive upd_valid with new data -> no change; then start -> RUN, identity reloaded, done=0.
- With VMAT_CONV_EN and CONV_TH=2: update differing by max 1 from the current matrix -> done=1, converged=1 at iter_cnt=1. Differing by 2 -> remains RUN.
- Without the macro, the same stimulus gives converged=0.
